sw_conditioner: RTL and testbench

Input conditioner for the board slide switches. It sits directly upstream of `system` and drives its SW bus. The block synchronises the raw 18-bit switch vector to clk and debounces it as a whole vector. It publishes a stable copy plus one-cycle change, rise and fall strobes, so the downstream stage never sees metastable or bouncing inputs.

---
 rtl/sw_conditioner.sv | 101 ++++++++++
 tb/tb_sw_conditioner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sw_conditioner.sv
// Slide-switch input conditioner: two-flop synchroniser followed by a
// whole-vector debounce FSM. Publishes a stable switch vector plus one-cycle
// change/rise/fall strobes for the downstream system stage.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | synchronised input matches sw_out, nothing pending
// SETTLING | candidate differs from sw_out, counting stable cycles
module sw_conditioner #(
  parameter int               WIDTH         = 18,
  parameter int               STABLE_CYCLES = 1000,
  parameter int               CNT_W         = 16,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             sw_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only sync2 is ever looked at by the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      candidate  <= '0;
      cnt        <= '0;
      sw_out     <= RST_VAL;
      sw_changed <= 1'b0;
      rise       <= '0;
      fall       <= '0;
      sw_stable  <= 1'b1;
    end else begin
      sw_changed <= 1'b0;
      rise       <= '0;
      fall       <= '0;
      case (state)
        IDLE: begin
          if (sync2 != sw_out) begin
            candidate <= sync2;
            cnt       <= '0;
            state     <= SETTLING;
            sw_stable <= 1'b0;
          end
        end
        SETTLING: begin
          if (sync2 == sw_out) begin
            // Input returned to the published value: drop the pending change.
            state     <= IDLE;
            sw_stable <= 1'b1;
          end else if (sync2 != candidate) begin
            // Any bit moving restarts the timer for the whole vector.
            candidate <= sync2;
            cnt       <= '0;
          end else if (cnt == CNT_LAST) begin
            sw_out     <= candidate;
            sw_changed <= 1'b1;
            rise       <= candidate & ~sw_out;
            fall       <= ~candidate & sw_out;
            state      <= IDLE;
            sw_stable  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          sw_stable <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_conditioner.sv
// Directed bench for sw_conditioner with a short settle time (4 cycles).
module tb_sw_conditioner;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out;
  logic         sw_changed;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         sw_stable;

  int vectors     = 0;
  int miscompares = 0;

  sw_conditioner #(
    .WIDTH(W),
    .STABLE_CYCLES(4),
    .CNT_W(16),
    .RST_VAL('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_out(sw_out),
    .sw_changed(sw_changed),
    .rise(rise),
    .fall(fall),
    .sw_stable(sw_stable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive raw (just after an edge) and follow the update edge by edge:
  // capture at E1, SETTLING from E3, sw_out changes at E7, pulse gone at E8.
  task automatic apply(input string tag, input logic [W-1:0] raw,
                       input logic [W-1:0] old_val, input logic [W-1:0] new_val,
                       input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall,
                       input bit check_stable);
    sw_raw = raw;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk({tag, "_chg"}, 32'(sw_changed), 32'(i == 7));
      if (check_stable)
        chk({tag, "_stable"}, 32'(sw_stable), 32'(!(i >= 3 && i <= 6)));
      if (i == 6) chk({tag, "_out_pre"}, 32'(sw_out), 32'(old_val));
      if (i == 7) begin
        chk({tag, "_out"}, 32'(sw_out), 32'(new_val));
        chk({tag, "_rise"}, 32'(rise), 32'(exp_rise));
        chk({tag, "_fall"}, 32'(fall), 32'(exp_fall));
      end
      if (i == 8) begin
        chk({tag, "_rise_clr"}, 32'(rise), 32'h0);
        chk({tag, "_fall_clr"}, 32'(fall), 32'h0);
      end
    end
  endtask

  initial begin
    int lows;

    // 1. Asynchronous reset before any clock edge, then release with input held high.
    sw_raw = 18'h3FFFF;
    #1 rst = 1'b0;
    #1;
    chk("rst_out", 32'(sw_out), 32'h0);
    chk("rst_chg", 32'(sw_changed), 32'h0);
    chk("rst_stable", 32'(sw_stable), 32'h1);
    chk("rst_rise", 32'(rise), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    apply("rst_rel", 18'h3FFFF, 18'h00000, 18'h3FFFF, 18'h3FFFF, 18'h00000, 1'b1);
    apply("clr", 18'h00000, 18'h3FFFF, 18'h00000, 18'h00000, 18'h3FFFF, 1'b1);

    // 3. Single-cycle glitch is rejected.
    sw_raw = 18'h00001;
    tick();
    sw_raw = 18'h00000;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      chk("glitch_chg", 32'(sw_changed), 32'h0);
      if (!sw_stable) lows++;
      tick();
    end
    chk("glitch_out", 32'(sw_out), 32'h0);
    chk("glitch_dip", 32'(lows), 32'd1);

    // 4. Bounce every 2 cycles, then hold; one event timed from the last transition.
    for (int k = 0; k < 4; k++) begin
      sw_raw = (k % 2 == 0) ? 18'h20000 : 18'h00000;
      tick();
      chk("bounce_chg", 32'(sw_changed), 32'h0);
      tick();
      chk("bounce_chg", 32'(sw_changed), 32'h0);
    end
    apply("bounce", 18'h20000, 18'h00000, 18'h20000, 18'h20000, 18'h00000, 1'b0);
    apply("back0", 18'h00000, 18'h20000, 18'h00000, 18'h00000, 18'h20000, 1'b1);

    // 2. Clean step.
    apply("step", 18'h0000F, 18'h00000, 18'h0000F, 18'h0000F, 18'h00000, 1'b1);

    // 5. Mixed rise and fall in one event.
    apply("mixed", 18'h10005, 18'h0000F, 18'h10005, 18'h10000, 18'h0000A, 1'b1);

    // 6. Reset while SETTLING with cnt=2 (after E5), then re-debounce after release.
    sw_raw = 18'h00003;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_settling", 32'(sw_stable), 32'h0);
    chk("mid_out_hold", 32'(sw_out), 32'h10005);
    rst = 1'b0;
    #1;
    chk("mid_rst_out", 32'(sw_out), 32'h0);
    chk("mid_rst_chg", 32'(sw_changed), 32'h0);
    chk("mid_rst_stable", 32'(sw_stable), 32'h1);
    chk("mid_rst_fall", 32'(fall), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    apply("mid_rel", 18'h00003, 18'h00000, 18'h00003, 18'h00003, 18'h00000, 1'b1);

    // Input equal to RST_VAL across reset produces no pulse.
    sw_raw = 18'h00000;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("quiet_chg", 32'(sw_changed), 32'h0);
      chk("quiet_stable", 32'(sw_stable), 32'h1);
    end
    chk("quiet_out", 32'(sw_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
